// File: rtl/riscv_soc.sv
// Minimal single-cycle RV32I SoC: combinational instruction ROM, single-cycle
// core with a 32x32 register file, and a word-addressed data RAM.
// One instruction retires on every rising clock edge.

// Instruction ROM: contents are loaded from outside, the design only reads it.
module riscv_rom #(
    parameter int ROM_DEPTH = 256,
    parameter int ROM_AW    = $clog2(ROM_DEPTH)
) (
    input  logic [ROM_AW-1:0] idx_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    // Combinational fetch of the addressed instruction word
    always_comb begin
        rdata_o = rom_mem[idx_i];
    end
endmodule

// Data RAM: combinational read, write on the rising edge, never cleared by reset.
module riscv_ram #(
    parameter int RAM_DEPTH = 256,
    parameter int RAM_AW    = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic [RAM_AW-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    input  logic              we_i,
    output logic [31:0]       rdata_o
);
    logic [31:0] ram_mem [0:RAM_DEPTH-1];

    // Combinational load data
    always_comb begin
        rdata_o = ram_mem[idx_i];
    end

    // Store word on the clock edge; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            ram_mem[idx_i] <= wdata_i;
        end
    end
endmodule

// Register file: two combinational read ports, one write port, x0 hardwired to 0.
module riscv_reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_val_o,
    output logic [31:0] rs2_val_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] rd_wdata_i
);
    logic [31:0] regs [0:31];

    // Combinational operand reads; x0 always reads as zero
    always_comb begin
        if (rs1_i == 5'd0) begin
            rs1_val_o = 32'd0;
        end else begin
            rs1_val_o = regs[rs1_i];
        end
        if (rs2_i == 5'd0) begin
            rs2_val_o = 32'd0;
        end else begin
            rs2_val_o = regs[rs2_i];
        end
    end

    // Asynchronous clear of all registers; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we_i && (rd_i != 5'd0)) begin
            regs[rd_i] <= rd_wdata_i;
        end
    end
endmodule

// Single-cycle RV32I core (integer subset, word loads/stores only).
module riscv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        dmem_we_o,
    input  logic [31:0] dmem_rdata_i
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_s;
    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic [31:0] alu_b_s, alu_res_s;
    logic        alu_alt_s;
    logic        op_valid_s, opimm_valid_s, branch_taken_s;
    logic [31:0] pc_plus4_s, next_pc_s, jalr_tgt_s;
    logic        rd_we_s;
    logic [31:0] rd_wdata_s;

    assign imem_addr_o = pc_q;
    assign instr_s     = imem_rdata_i;

    riscv_reg_file reg_file_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_i      (rs1_s),
        .rs2_i      (rs2_s),
        .rs1_val_o  (rs1_val_s),
        .rs2_val_o  (rs2_val_s),
        .we_i       (rd_we_s),
        .rd_i       (rd_s),
        .rd_wdata_i (rd_wdata_s)
    );

    // Field extraction and sign-extended immediates
    always_comb begin
        opcode_s = instr_s[6:0];
        rd_s     = instr_s[11:7];
        funct3_s = instr_s[14:12];
        rs1_s    = instr_s[19:15];
        rs2_s    = instr_s[24:20];
        funct7_s = instr_s[31:25];
        imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
        imm_s_s  = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
        imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
        imm_u_s  = {instr_s[31:12], 12'd0};
        imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    end

    // Encoding legality for register and immediate ALU forms
    always_comb begin
        op_valid_s = (funct7_s == 7'b0000000) ||
                     ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
        case (funct3_s)
            3'b001:  opimm_valid_s = (funct7_s == 7'b0000000);
            3'b101:  opimm_valid_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
            default: opimm_valid_s = 1'b1;
        endcase
    end

    // Shared ALU; instr[30] selects SUB (register form only) and SRA/SRAI
    always_comb begin
        if (opcode_s == OPC_OP) begin
            alu_b_s   = rs2_val_s;
            alu_alt_s = instr_s[30];
        end else begin
            alu_b_s   = imm_i_s;
            alu_alt_s = 1'b0;
        end
        case (funct3_s)
            3'b000:  alu_res_s = alu_alt_s ? (rs1_val_s - alu_b_s) : (rs1_val_s + alu_b_s);
            3'b001:  alu_res_s = rs1_val_s << alu_b_s[4:0];
            3'b010:  alu_res_s = {31'd0, $signed(rs1_val_s) < $signed(alu_b_s)};
            3'b011:  alu_res_s = {31'd0, rs1_val_s < alu_b_s};
            3'b100:  alu_res_s = rs1_val_s ^ alu_b_s;
            3'b101:  alu_res_s = instr_s[30] ? $unsigned($signed(rs1_val_s) >>> alu_b_s[4:0])
                                             : (rs1_val_s >> alu_b_s[4:0]);
            3'b110:  alu_res_s = rs1_val_s | alu_b_s;
            3'b111:  alu_res_s = rs1_val_s & alu_b_s;
            default: alu_res_s = 32'd0;
        endcase
    end

    // Branch condition; reserved funct3 codes never branch
    always_comb begin
        case (funct3_s)
            3'b000:  branch_taken_s = (rs1_val_s == rs2_val_s);
            3'b001:  branch_taken_s = (rs1_val_s != rs2_val_s);
            3'b100:  branch_taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            3'b101:  branch_taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            3'b110:  branch_taken_s = (rs1_val_s < rs2_val_s);
            3'b111:  branch_taken_s = (rs1_val_s >= rs2_val_s);
            default: branch_taken_s = 1'b0;
        endcase
    end

    // Main control: writeback, memory request and next pc; unknown encodings fall through as NOP
    always_comb begin
        pc_plus4_s   = pc_q + 32'd4;
        jalr_tgt_s   = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
        next_pc_s    = pc_plus4_s;
        rd_we_s      = 1'b0;
        rd_wdata_s   = 32'd0;
        dmem_we_o    = 1'b0;
        dmem_wdata_o = rs2_val_s;
        dmem_addr_o  = rs1_val_s + imm_i_s;
        case (opcode_s)
            OPC_LUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = imm_u_s;
            end
            OPC_AUIPC: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_q + imm_u_s;
            end
            OPC_JAL: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                next_pc_s  = pc_q + imm_j_s;
            end
            OPC_JALR: begin
                if (funct3_s == 3'b000) begin
                    rd_we_s    = 1'b1;
                    rd_wdata_s = pc_plus4_s;
                    next_pc_s  = jalr_tgt_s;
                end else begin
                    rd_we_s    = 1'b0;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken_s) begin
                    next_pc_s = pc_q + imm_b_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OPC_LOAD: begin
                if (funct3_s == 3'b010) begin
                    rd_we_s    = 1'b1;
                    rd_wdata_s = dmem_rdata_i;
                end else begin
                    rd_we_s    = 1'b0;
                end
            end
            OPC_STORE: begin
                dmem_addr_o = rs1_val_s + imm_s_s;
                if (funct3_s == 3'b010) begin
                    dmem_we_o = 1'b1;
                end else begin
                    dmem_we_o = 1'b0;
                end
            end
            OPC_OPIMM: begin
                rd_we_s    = opimm_valid_s;
                rd_wdata_s = alu_res_s;
            end
            OPC_OP: begin
                rd_we_s    = op_valid_s;
                rd_wdata_s = alu_res_s;
            end
            default: begin
                rd_we_s = 1'b0;
            end
        endcase
        pc_d = {next_pc_s[31:2], 2'b00};
    end

    // Program counter; cleared to the reset vector immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// SoC top: ROM, core and RAM wired together.
module riscv_soc #(
    parameter int          ROM_DEPTH = 256,
    parameter int          RAM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [31:0] imem_addr_s, imem_rdata_s;
    logic [31:0] dmem_addr_s, dmem_wdata_s, dmem_rdata_s;
    logic        dmem_we_s;

    riscv_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_1 (
        .idx_i   (imem_addr_s[ROM_AW+1:2]),
        .rdata_o (imem_rdata_s)
    );

    riscv_core #(.RESET_PC(RESET_PC)) top_1 (
        .clk          (clk),
        .rst_n        (reset),
        .imem_addr_o  (imem_addr_s),
        .imem_rdata_i (imem_rdata_s),
        .dmem_addr_o  (dmem_addr_s),
        .dmem_wdata_o (dmem_wdata_s),
        .dmem_we_o    (dmem_we_s),
        .dmem_rdata_i (dmem_rdata_s)
    );

    riscv_ram #(.RAM_DEPTH(RAM_DEPTH)) ram_1 (
        .clk     (clk),
        .idx_i   (dmem_addr_s[RAM_AW+1:2]),
        .wdata_i (dmem_wdata_s),
        .we_i    (dmem_we_s),
        .rdata_o (dmem_rdata_s)
    );
endmodule

// File: tb/tb_riscv_soc.sv
// Directed, table-driven bench for riscv_soc: each record is a short program
// plus the register values and pc expected after a given number of edges.
module tb_riscv_soc;
    logic clk;
    logic reset;

    int total;
    int bad;

    riscv_soc dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [5:0][31:0] prog;
        int               n_instr;
        int               n_edges;
        logic [2:0][4:0]  rr;
        logic [2:0][31:0] rv;
        logic [31:0]      pc_exp;
    } vec_t;

    vec_t vecs [0:7];

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count nonzero registers, ignoring those whose bit is set in skip
    task automatic count_nonzero(input logic [31:0] skip, output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (!skip[i] && (dut.top_1.reg_file_1.regs[i] !== 32'd0)) begin
                n++;
            end
        end
    endtask

    task automatic load_rom(input int t);
        for (int i = 0; i < 256; i++) begin
            dut.rom_1.rom_mem[i] = 32'd0;
        end
        for (int i = 0; i < vecs[t].n_instr; i++) begin
            dut.rom_1.rom_mem[i] = vecs[t].prog[i];
        end
    endtask

    task automatic check_final(input int t, input string tag);
        logic [4:0] r;
        for (int k = 0; k < 3; k++) begin
            r = vecs[t].rr[k];
            check($sformatf("%s_v%0d_x%0d", tag, t, r), dut.top_1.reg_file_1.regs[r], vecs[t].rv[k]);
        end
        check($sformatf("%s_v%0d_pc", tag, t), dut.top_1.pc_q, vecs[t].pc_exp);
    endtask

    task automatic set_vec(input int t, input int ni, input int ne,
                           input logic [4:0] r0, input logic [31:0] v0,
                           input logic [4:0] r1, input logic [31:0] v1,
                           input logic [4:0] r2, input logic [31:0] v2,
                           input logic [31:0] pce);
        vecs[t].n_instr = ni;
        vecs[t].n_edges = ne;
        vecs[t].rr[0] = r0; vecs[t].rv[0] = v0;
        vecs[t].rr[1] = r1; vecs[t].rv[1] = v1;
        vecs[t].rr[2] = r2; vecs[t].rv[2] = v2;
        vecs[t].pc_exp = pce;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b0;

        for (int t = 0; t < 8; t++) begin
            vecs[t].prog = '0;
        end
        // ADDI/ADDI/ADD
        vecs[0].prog[0] = enc_i(7'b0010011, 5'd27, 3'b000, 5'd0, 12'd5);
        vecs[0].prog[1] = enc_i(7'b0010011, 5'd28, 3'b000, 5'd0, 12'd7);
        vecs[0].prog[2] = enc_r(7'b0000000, 5'd28, 5'd27, 3'b000, 5'd29);
        set_vec(0, 3, 3, 5'd27, 32'd5, 5'd28, 32'd7, 5'd29, 32'd12, 32'd12);
        // logical vs arithmetic right shift of -1
        vecs[1].prog[0] = enc_i(7'b0010011, 5'd27, 3'b000, 5'd0, 12'hFFF);
        vecs[1].prog[1] = enc_i(7'b0010011, 5'd28, 3'b101, 5'd27, {7'b0000000, 5'd28});
        vecs[1].prog[2] = enc_i(7'b0010011, 5'd29, 3'b101, 5'd27, {7'b0100000, 5'd28});
        set_vec(1, 3, 3, 5'd27, 32'hFFFF_FFFF, 5'd28, 32'd15, 5'd29, 32'hFFFF_FFFF, 32'd12);
        // store then load through RAM word 2
        vecs[2].prog[0] = enc_i(7'b0010011, 5'd1, 3'b000, 5'd0, 12'd42);
        vecs[2].prog[1] = enc_s(12'd8, 5'd1, 5'd0);
        vecs[2].prog[2] = enc_i(7'b0000011, 5'd27, 3'b010, 5'd0, 12'd8);
        set_vec(2, 3, 3, 5'd27, 32'd42, 5'd1, 32'd42, 5'd0, 32'd0, 32'd12);
        // counted loop then JAL-to-self
        vecs[3].prog[0] = enc_i(7'b0010011, 5'd27, 3'b000, 5'd0, 12'd3);
        vecs[3].prog[1] = enc_i(7'b0010011, 5'd28, 3'b000, 5'd28, 12'd1);
        vecs[3].prog[2] = enc_b(13'h1FFC, 5'd27, 5'd28, 3'b001);
        vecs[3].prog[3] = enc_j(5'd29, 21'd0);
        set_vec(3, 4, 12, 5'd27, 32'd3, 5'd28, 32'd3, 5'd29, 32'd16, 32'd12);
        // write to x0 discarded; LUI
        vecs[4].prog[0] = enc_i(7'b0010011, 5'd0, 3'b000, 5'd0, 12'd9);
        vecs[4].prog[1] = enc_u(7'b0110111, 5'd27, 20'h12345);
        set_vec(4, 2, 2, 5'd0, 32'd0, 5'd27, 32'h1234_5000, 5'd28, 32'd0, 32'd8);
        // SUB / SLT / SLTU with a negative operand
        vecs[5].prog[0] = enc_i(7'b0010011, 5'd1, 3'b000, 5'd0, 12'hFFB);
        vecs[5].prog[1] = enc_i(7'b0010011, 5'd2, 3'b000, 5'd0, 12'd3);
        vecs[5].prog[2] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        vecs[5].prog[3] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4);
        vecs[5].prog[4] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd5);
        set_vec(5, 5, 5, 5'd3, 32'hFFFF_FFF8, 5'd4, 32'd1, 5'd5, 32'd0, 32'd20);
        // JALR with rd == rs1 and odd target, then AUIPC
        vecs[6].prog[0] = enc_i(7'b0010011, 5'd1, 3'b000, 5'd0, 12'd12);
        vecs[6].prog[1] = enc_i(7'b1100111, 5'd1, 3'b000, 5'd1, 12'd1);
        vecs[6].prog[2] = enc_i(7'b0010011, 5'd2, 3'b000, 5'd0, 12'd99);
        vecs[6].prog[3] = enc_u(7'b0010111, 5'd3, 20'd1);
        set_vec(6, 4, 3, 5'd1, 32'd8, 5'd2, 32'd0, 5'd3, 32'h0000_100C, 32'd16);
        // BLT taken (signed), BLTU not taken (unsigned)
        vecs[7].prog[0] = enc_i(7'b0010011, 5'd1, 3'b000, 5'd0, 12'hFFF);
        vecs[7].prog[1] = enc_b(13'd8, 5'd0, 5'd1, 3'b100);
        vecs[7].prog[2] = enc_i(7'b0010011, 5'd2, 3'b000, 5'd0, 12'd1);
        vecs[7].prog[3] = enc_b(13'd8, 5'd0, 5'd1, 3'b110);
        vecs[7].prog[4] = enc_i(7'b0010011, 5'd3, 3'b000, 5'd0, 12'd7);
        set_vec(7, 5, 4, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd0, 5'd3, 32'd7, 32'd20);

        // Reset state
        #1;
        check("reset_pc", dut.top_1.pc_q, 32'd0);
        count_nonzero(32'd0, n);
        check("reset_regs_nonzero", n, 32'd0);

        for (int t = 0; t < 8; t++) begin
            reset = 1'b0;
            load_rom(t);
            @(negedge clk);
            reset = 1'b1;
            repeat (vecs[t].n_edges) @(posedge clk);
            @(negedge clk);
            check_final(t, "vec");
            if (t == 0) begin
                count_nonzero(32'h3800_0000, n);
                check("v0_other_regs_nonzero", n, 32'd0);
            end
            if (t == 2) begin
                check("v2_ram_word2", dut.ram_1.ram_mem[2], 32'd42);
            end
        end

        // Mid-program reset: clears asynchronously, holds, then replays
        reset = 1'b0;
        load_rom(3);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_pre_x28", dut.top_1.reg_file_1.regs[28], 32'd2);
        check("mid_pre_pc", dut.top_1.pc_q, 32'd8);
        #3;
        reset = 1'b0;
        #1;
        check("mid_async_pc", dut.top_1.pc_q, 32'd0);
        count_nonzero(32'd0, n);
        check("mid_async_regs_nonzero", n, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_hold_pc", dut.top_1.pc_q, 32'd0);
        count_nonzero(32'd0, n);
        check("mid_hold_regs_nonzero", n, 32'd0);
        check("ram_kept_over_reset", dut.ram_1.ram_mem[2], 32'd42);
        reset = 1'b1;
        repeat (vecs[3].n_edges) @(posedge clk);
        @(negedge clk);
        check_final(3, "replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
